pa_ifu_icache_refill_wr: RTL and testbench
==========================================

Name: pa_ifu_icache_refill_wr

Overview:
- Refill write controller directly upstream of the icache data array.
- Accepts 32-bit refill beats from the BIU for one 16-byte line, wrapping critical-word-first, into a small beat buffer.
- Arbitrates array-port access between fetch reads and refill writes, and drives the array's cen/wen/din/idx.
- Reports refill completion or bus error to the icache control FSM.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two; word offset is the low log2 bits of idx.
- IDX_WIDTH, 13, array word-index width (set index concatenated with word offset).
- BUF_DEPTH, 2, refill beat buffer entries; power of two, ≥2.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- refill_req  in  1  start-refill pulse; ignored while refill_busy
- refill_way  in  1  target way
- refill_set_idx  in  IDX_WIDTH-2  set index
- refill_word_ofs  in  2  critical word offset
- biu_ifu_rdata_vld  in  1  beat valid
- biu_ifu_rdata  in  32  beat data
- biu_ifu_rdata_last  in  1  final beat
- biu_ifu_rdata_err  in  1  bus error on beat
- ifu_biu_rdata_rdy  out  1  beat accept
- fetch_rd_req  in  1  fetch read request
- fetch_rd_cen  in  2  fetch way enables
- fetch_rd_idx  in  IDX_WIDTH  fetch word index
- fetch_rd_gnt  out  1  fetch read granted this cycle
- icache_data_cen  out  2  array way enables
- icache_data_wen  out  2  array way write enables
- icache_data_din  out  32  array write data
- icache_data_idx  out  IDX_WIDTH  array index
- refill_busy  out  1  refill in progress
- refill_done  out  1  one-cycle pulse: line fully written
- refill_err  out  1  one-cycle pulse: refill aborted

Behaviour:
- Reset: FSM in IDLE; buffer empty; word counter and write offset 0; all outputs 0 except fetch_rd_gnt, which follows its combinational rule (= fetch_rd_req).
- FSM states:
  - IDLE: on refill_req, latch way/set/ofs, go to FILL; busy=1 from the next cycle.
  - FILL: ifu_biu_rdata_rdy = buffer not full. An accepted beat pushes {data}, and the write offset advances by 1 mod LINE_WORDS.
  - Leaving FILL:
    - Accepted beat with err → FLUSH.
    - Accepted beat with last, and beat count == LINE_WORDS → DRAIN.
    - last before LINE_WORDS beats, or LINE_WORDS beats without last → treat as err → FLUSH.
  - DRAIN: rdy=0. When the buffer is empty and all LINE_WORDS writes are done, pulse refill_done and go to IDLE (busy drops the same cycle).
  - FLUSH: clear the buffer immediately and suppress pending writes; rdy=1; discard beats until last is accepted (or immediately if the error beat carried last). Then pulse refill_err and go to IDLE.
- Arbitration, combinational, each cycle:
  - Write issues if buffer non-empty AND (fetch_rd_req==0 OR buffer full).
  - Otherwise fetch_rd_gnt = fetch_rd_req.
  - Write and grant never both asserted.
  - Outputs on a write: cen = wen = one-hot(latched way); din = buffer head; idx = {set, ofs_wr}. The write pops the head and advances ofs_wr mod LINE_WORDS from the latched critical offset.
  - Outputs on a grant: cen = fetch_rd_cen; wen = 0; idx = fetch_rd_idx.
  - Outputs otherwise: cen = wen = 0; idx/din hold 0.
- Simultaneous push and pop on the same cycle is legal when the buffer is full (occupancy unchanged). A push-only cycle at full cannot occur because rdy=0.
- Latency: a beat accepted in cycle N is written to the array no earlier than cycle N+1. With no fetch traffic it is written exactly at N+1.
- Reset asserted mid-refill: immediate return to IDLE, buffer cleared, no done/err pulse.

Optional Feature:
- Macro: ICACHE_CRIT_WORD_BYPASS_EN.
- Defined:
  - Adds outputs refill_byp_vld (1) and refill_byp_data (32).
  - refill_byp_vld pulses combinationally in the cycle the first beat of a refill is accepted without err; data = biu_ifu_rdata.
  - Lets fetch consume the critical word before the array write.
- Undefined: ports absent; no bypass.

Decomposition:
- Shared package pa_ifu_icache_pkg holds:
  - FSM state encodings IDLE/FILL/DRAIN/FLUSH
  - LINE_WORDS and IDX_WIDTH defaults
  - way one-hot decode helper
- Sub-module pa_ifu_icache_refill_buf: BUF_DEPTH×32 FIFO with push/pop/full/empty/flush.

Test Plan:
- Refill way1, set 0x155, ofs 2, beats A0..A3 back-to-back, no fetch → writes at idx 0x556, 0x557, 0x554, 0x555 in consecutive cycles, wen=2'b10; refill_done one cycle after the last write.
- Same refill with fetch_rd_req held high → fetch granted until the buffer reaches 2 entries; then the write wins and gnt=0; rdy drops while full; all 4 words are eventually written in wrap order.
- biu_ifu_rdata_err on beat 1 (last on beat 3) → beat 0 written, beat 1 never written; beats 2-3 accepted and discarded; refill_err pulses once; refill_done never asserts.
- last asserted on beat 2 → FLUSH, refill_err pulse, return to IDLE; a new refill_req the next cycle is accepted.
- cpurst_b low for one cycle after 2 beats → busy=0, cen=0, no pulses; a subsequent refill completes normally.
- With ICACHE_CRIT_WORD_BYPASS_EN: refill_byp_vld=1 and refill_byp_data=0xDEADBEEF in the same cycle the first beat (0xDEADBEEF) is accepted, and never again in that refill.

Source files
------------

// File: rtl/pa_ifu_icache_pkg.sv
// Shared icache refill definitions: FSM encoding, default geometry, way decode.
package pa_ifu_icache_pkg;

    localparam int LINE_WORDS_DEF = 4;
    localparam int IDX_WIDTH_DEF  = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } refill_st_e;

    function automatic logic [1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pa_ifu_icache_refill_buf.sv
// Small refill beat FIFO; flush empties it in one cycle and overrides push/pop.
module pa_ifu_icache_refill_buf #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

endmodule

// File: rtl/pa_ifu_icache_refill_wr.sv
// Icache refill write controller: buffers BIU beats and arbitrates the data array port with fetch.
// Optional critical-word bypass outputs are built when ICACHE_CRIT_WORD_BYPASS_EN is defined.
module pa_ifu_icache_refill_wr
    import pa_ifu_icache_pkg::*;
#(
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    parameter  int IDX_WIDTH  = IDX_WIDTH_DEF,
    parameter  int BUF_DEPTH  = 2,
    localparam int OFS_W      = $clog2(LINE_WORDS),
    localparam int SET_W      = IDX_WIDTH - OFS_W,
    localparam int CNT_W      = OFS_W + 1
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 refill_req,
    input  logic                 refill_way,
    input  logic [SET_W-1:0]     refill_set_idx,
    input  logic [OFS_W-1:0]     refill_word_ofs,
    input  logic                 biu_ifu_rdata_vld,
    input  logic [31:0]          biu_ifu_rdata,
    input  logic                 biu_ifu_rdata_last,
    input  logic                 biu_ifu_rdata_err,
    output logic                 ifu_biu_rdata_rdy,
    input  logic                 fetch_rd_req,
    input  logic [1:0]           fetch_rd_cen,
    input  logic [IDX_WIDTH-1:0] fetch_rd_idx,
    output logic                 fetch_rd_gnt,
    output logic [1:0]           icache_data_cen,
    output logic [1:0]           icache_data_wen,
    output logic [31:0]          icache_data_din,
    output logic [IDX_WIDTH-1:0] icache_data_idx,
    output logic                 refill_busy,
    output logic                 refill_done,
    output logic                 refill_err
`ifdef ICACHE_CRIT_WORD_BYPASS_EN
   ,output logic                 refill_byp_vld,
    output logic [31:0]          refill_byp_data
`endif
);

    refill_st_e       state, state_nxt;
    logic             way_q;
    logic [SET_W-1:0] set_q;
    logic [OFS_W-1:0] ofs_wr;
    logic [CNT_W-1:0] beat_cnt, wr_cnt, beat_cnt_nxt;
    logic             flush_last_q;

    logic             buf_full, buf_empty, buf_push, buf_flush;
    logic [31:0]      buf_head;
    logic             wr_issue, beat_acc;

    assign beat_cnt_nxt = beat_cnt + CNT_W'(1);

    // Writes yield to fetch unless the buffer is full, so beats never stall behind fetch forever.
    assign wr_issue = (state == ST_FILL || state == ST_DRAIN) && !buf_empty
                      && (!fetch_rd_req || buf_full);
    assign fetch_rd_gnt      = fetch_rd_req && !wr_issue;
    assign ifu_biu_rdata_rdy = (state == ST_FILL && !buf_full) || state == ST_FLUSH;
    assign beat_acc          = biu_ifu_rdata_vld && ifu_biu_rdata_rdy;
    assign buf_push          = state == ST_FILL && beat_acc && !biu_ifu_rdata_err;
    assign buf_flush         = state == ST_FLUSH;
    assign refill_busy       = state != ST_IDLE;

    pa_ifu_icache_refill_buf #(
        .DEPTH (BUF_DEPTH),
        .DW    (32)
    ) u_buf (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .flush     (buf_flush),
        .push      (buf_push),
        .push_data (biu_ifu_rdata),
        .pop       (wr_issue),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        state_nxt   = state;
        refill_done = 1'b0;
        refill_err  = 1'b0;
        case (state)
            ST_IDLE: if (refill_req) state_nxt = ST_FILL;
            ST_FILL: begin
                if (beat_acc) begin
                    if (biu_ifu_rdata_err)
                        state_nxt = ST_FLUSH;
                    else if (biu_ifu_rdata_last && beat_cnt_nxt == CNT_W'(LINE_WORDS))
                        state_nxt = ST_DRAIN;
                    else if (biu_ifu_rdata_last || beat_cnt_nxt == CNT_W'(LINE_WORDS))
                        state_nxt = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (buf_empty && wr_cnt == CNT_W'(LINE_WORDS)) begin
                    refill_done = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_last_q || (beat_acc && biu_ifu_rdata_last)) begin
                    refill_err = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            way_q        <= 1'b0;
            set_q        <= '0;
            ofs_wr       <= '0;
            beat_cnt     <= '0;
            wr_cnt       <= '0;
            flush_last_q <= 1'b0;
        end else if (state == ST_IDLE && refill_req) begin
            way_q        <= refill_way;
            set_q        <= refill_set_idx;
            ofs_wr       <= refill_word_ofs;
            beat_cnt     <= '0;
            wr_cnt       <= '0;
            flush_last_q <= 1'b0;
        end else begin
            if (buf_push) beat_cnt <= beat_cnt_nxt;
            if (wr_issue) begin
                ofs_wr <= ofs_wr + OFS_W'(1);
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            // Remember whether the aborting beat already closed the burst.
            if (state == ST_FILL && state_nxt == ST_FLUSH)
                flush_last_q <= biu_ifu_rdata_last;
        end
    end

    always_comb begin
        icache_data_cen = 2'b00;
        icache_data_wen = 2'b00;
        icache_data_din = '0;
        icache_data_idx = '0;
        if (wr_issue) begin
            icache_data_cen = way_onehot(way_q);
            icache_data_wen = way_onehot(way_q);
            icache_data_din = buf_head;
            icache_data_idx = {set_q, ofs_wr};
        end else if (fetch_rd_gnt) begin
            icache_data_cen = fetch_rd_cen;
            icache_data_idx = fetch_rd_idx;
        end
    end

`ifdef ICACHE_CRIT_WORD_BYPASS_EN
    assign refill_byp_vld  = state == ST_FILL && beat_acc && !biu_ifu_rdata_err
                             && beat_cnt == '0;
    assign refill_byp_data = biu_ifu_rdata;
`endif

endmodule

// File: tb/tb_pa_ifu_icache_refill_wr.sv
// Randomized bench for pa_ifu_icache_refill_wr against a transaction-level reference model.
module tb_pa_ifu_icache_refill_wr;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b;
    logic        refill_req, refill_way;
    logic [10:0] refill_set_idx;
    logic [1:0]  refill_word_ofs;
    logic        biu_ifu_rdata_vld, biu_ifu_rdata_last, biu_ifu_rdata_err;
    logic [31:0] biu_ifu_rdata;
    logic        ifu_biu_rdata_rdy;
    logic        fetch_rd_req;
    logic [1:0]  fetch_rd_cen;
    logic [12:0] fetch_rd_idx;
    logic        fetch_rd_gnt;
    logic [1:0]  icache_data_cen, icache_data_wen;
    logic [31:0] icache_data_din;
    logic [12:0] icache_data_idx;
    logic        refill_busy, refill_done, refill_err;
`ifdef ICACHE_CRIT_WORD_BYPASS_EN
    logic        refill_byp_vld;
    logic [31:0] refill_byp_data;
`endif

    pa_ifu_icache_refill_wr dut (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst_b           (cpurst_b),
        .refill_req         (refill_req),
        .refill_way         (refill_way),
        .refill_set_idx     (refill_set_idx),
        .refill_word_ofs    (refill_word_ofs),
        .biu_ifu_rdata_vld  (biu_ifu_rdata_vld),
        .biu_ifu_rdata      (biu_ifu_rdata),
        .biu_ifu_rdata_last (biu_ifu_rdata_last),
        .biu_ifu_rdata_err  (biu_ifu_rdata_err),
        .ifu_biu_rdata_rdy  (ifu_biu_rdata_rdy),
        .fetch_rd_req       (fetch_rd_req),
        .fetch_rd_cen       (fetch_rd_cen),
        .fetch_rd_idx       (fetch_rd_idx),
        .fetch_rd_gnt       (fetch_rd_gnt),
        .icache_data_cen    (icache_data_cen),
        .icache_data_wen    (icache_data_wen),
        .icache_data_din    (icache_data_din),
        .icache_data_idx    (icache_data_idx),
        .refill_busy        (refill_busy),
        .refill_done        (refill_done),
        .refill_err         (refill_err)
`ifdef ICACHE_CRIT_WORD_BYPASS_EN
       ,.refill_byp_vld     (refill_byp_vld),
        .refill_byp_data    (refill_byp_data)
`endif
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    typedef struct {
        logic [12:0] idx;
        logic [31:0] d;
    } wr_t;

    int checks = 0, errors = 0;

    // Reference model: phase 0 idle, 1 collecting beats, 2 line complete, 3 discarding.
    int          phase = 0, beats = 0, mofs = 0;
    bit          mway, flast, last_acc;
    logic [10:0] mset;
    wr_t         pend[$];
    wr_t         wlog[$];
    int          obs_done, obs_err, obs_byp;

    logic [31:0] bd[8];
    bit          bl[8], be[8];
    int          nb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are already driven; sample mid-cycle, compare, advance the model, move past the edge.
    task automatic step();
        int         occ;
        bit         wr_e, rdy_e, acc, done_e, err_e;
        logic [1:0] oh;
        wr_t        w;
        #4;
        occ      = pend.size();
        last_acc = 1'b0;
        obs_done += int'(refill_done);
        obs_err  += int'(refill_err);
        if (!cpurst_b) begin
            chk("rst_busy", refill_busy, 0);
            chk("rst_rdy", ifu_biu_rdata_rdy, 0);
            chk("rst_done", refill_done, 0);
            chk("rst_err", refill_err, 0);
            chk("rst_gnt", fetch_rd_gnt, fetch_rd_req);
            if (!fetch_rd_req)
                chk("rst_arr", {icache_data_cen, icache_data_wen, icache_data_idx, icache_data_din}, 0);
            phase = 0;
            pend.delete();
        end else begin
            wr_e   = (phase == 1 || phase == 2) && occ > 0 && (!fetch_rd_req || occ == 2);
            rdy_e  = (phase == 1 && occ < 2) || phase == 3;
            acc    = biu_ifu_rdata_vld && rdy_e;
            done_e = phase == 2 && occ == 0;
            err_e  = phase == 3 && (flast || (acc && biu_ifu_rdata_last));
            oh     = mway ? 2'b10 : 2'b01;
            chk("busy", refill_busy, phase != 0);
            chk("rdy", ifu_biu_rdata_rdy, rdy_e);
            chk("done", refill_done, done_e);
            chk("err", refill_err, err_e);
            chk("wr_issue", |icache_data_wen, wr_e);
            chk("gnt", fetch_rd_gnt, fetch_rd_req && !wr_e);
            if (wr_e) begin
                w = pend.pop_front();
                chk("wr_cen", icache_data_cen, oh);
                chk("wr_wen", icache_data_wen, oh);
                chk("wr_idx", icache_data_idx, w.idx);
                chk("wr_din", icache_data_din, w.d);
                wlog.push_back(w);
            end else if (fetch_rd_req) begin
                chk("rd_cen", icache_data_cen, fetch_rd_cen);
                chk("rd_wen", icache_data_wen, 0);
                chk("rd_idx", icache_data_idx, fetch_rd_idx);
            end else begin
                chk("idle_arr", {icache_data_cen, icache_data_wen, icache_data_idx, icache_data_din}, 0);
            end
`ifdef ICACHE_CRIT_WORD_BYPASS_EN
            obs_byp += int'(refill_byp_vld);
            chk("byp_vld", refill_byp_vld, phase == 1 && acc && !biu_ifu_rdata_err && beats == 0);
            if (refill_byp_vld) chk("byp_data", refill_byp_data, biu_ifu_rdata);
`endif
            last_acc = acc;
            case (phase)
                0: if (refill_req) begin
                    phase = 1; beats = 0; flast = 0;
                    mway = refill_way; mset = refill_set_idx; mofs = int'(refill_word_ofs);
                    pend.delete();
                end
                1: if (acc) begin
                    if (biu_ifu_rdata_err) begin
                        phase = 3; flast = biu_ifu_rdata_last; pend.delete();
                    end else begin
                        w.idx = {mset, 2'((mofs + beats) % 4)};
                        w.d   = biu_ifu_rdata;
                        pend.push_back(w);
                        beats++;
                        if (biu_ifu_rdata_last && beats == 4) phase = 2;
                        else if (biu_ifu_rdata_last || beats == 4) begin
                            phase = 3; flast = biu_ifu_rdata_last; pend.delete();
                        end
                    end
                end
                2: if (done_e) phase = 0;
                3: begin
                    pend.delete();
                    if (err_e) phase = 0;
                end
                default: phase = 0;
            endcase
        end
        @(posedge forever_cpuclk);
        #1;
    endtask

    // kind 0 good line, 1 error on beat k, 2 early last on beat k, 3 four beats without last.
    task automatic set_beats(input int kind, input int k);
        for (int i = 0; i < 8; i++) begin
            bd[i] = $urandom; bl[i] = 0; be[i] = 0;
        end
        case (kind)
            1:       begin nb = 4; be[k] = 1; bl[3] = 1; end
            2:       begin nb = k + 1; bl[k] = 1; end
            3:       begin nb = 6; bl[5] = 1; end
            default: begin nb = 4; bl[3] = 1; end
        endcase
    endtask

    task automatic run_txn(input bit way, input logic [10:0] set, input logic [1:0] ofs,
                           input int fprob, input int vprob, input int rst_after,
                           input int exp_done, input int exp_err);
        int bi, cyc;
        refill_req = 1; refill_way = way; refill_set_idx = set; refill_word_ofs = ofs;
        biu_ifu_rdata_vld = 0; fetch_rd_req = 0;
        obs_done = 0; obs_err = 0; obs_byp = 0;
        wlog.delete();
        step();
        refill_req = 0;
        bi = 0; cyc = 0;
        while ((phase != 0 || bi < nb) && cyc < 300) begin
            if (bi == rst_after) begin
                cpurst_b = 0; biu_ifu_rdata_vld = 0; fetch_rd_req = 0;
                step();
                cpurst_b = 1;
                bi = nb;
            end else begin
                fetch_rd_req = (bi < nb) ? ($urandom_range(99) < fprob) : 1'($urandom_range(1));
                fetch_rd_cen = 2'($urandom);
                fetch_rd_idx = 13'($urandom);
                if (bi < nb) begin
                    biu_ifu_rdata_vld  = $urandom_range(99) < vprob;
                    biu_ifu_rdata      = bd[bi];
                    biu_ifu_rdata_last = bl[bi];
                    biu_ifu_rdata_err  = be[bi];
                end else begin
                    biu_ifu_rdata_vld  = 0;
                    biu_ifu_rdata      = $urandom;
                    biu_ifu_rdata_last = 1'($urandom);
                    biu_ifu_rdata_err  = 1'($urandom);
                end
                step();
                if (last_acc) bi++;
            end
            cyc++;
        end
        if (cyc >= 300) chk("timeout", cyc, 0);
        biu_ifu_rdata_vld = 0; fetch_rd_req = 0;
        chk("done_cnt", obs_done, exp_done);
        chk("err_cnt", obs_err, exp_err);
`ifdef ICACHE_CRIT_WORD_BYPASS_EN
        if (rst_after < 0) chk("byp_cnt", obs_byp, (!be[0]) ? 1 : 0);
`endif
    endtask

    initial begin
        logic [12:0] e1[4];
        int kind, k;
        e1 = '{13'h556, 13'h557, 13'h554, 13'h555};
        cpurst_b = 0; refill_req = 0; refill_way = 0; refill_set_idx = 0; refill_word_ofs = 0;
        biu_ifu_rdata_vld = 0; biu_ifu_rdata = 0; biu_ifu_rdata_last = 0; biu_ifu_rdata_err = 0;
        fetch_rd_req = 0; fetch_rd_cen = 0; fetch_rd_idx = 0;
        step();
        fetch_rd_req = 1; fetch_rd_cen = 2'b11; fetch_rd_idx = 13'h1abc;
        step();
        cpurst_b = 1; fetch_rd_req = 0;
        step();

        // Critical-word-first wrap, no fetch traffic.
        set_beats(0, 0);
        for (int i = 0; i < 4; i++) bd[i] = 32'ha0a0_0000 + 32'(i);
        bd[0] = 32'hdeadbeef;
        run_txn(1, 11'h155, 2'd2, 0, 100, -1, 1, 0);
        chk("t1_nwr", wlog.size(), 4);
        for (int i = 0; i < wlog.size() && i < 4; i++) begin
            chk("t1_idx", wlog[i].idx, e1[i]);
            chk("t1_din", wlog[i].d, bd[i]);
        end

        // Same refill against a fetch stream held high while beats arrive.
        run_txn(1, 11'h155, 2'd2, 100, 100, -1, 1, 0);
        chk("t2_nwr", wlog.size(), 4);
        for (int i = 0; i < wlog.size() && i < 4; i++) chk("t2_idx", wlog[i].idx, e1[i]);

        // Error on beat 1, last on beat 3.
        set_beats(1, 1);
        run_txn(0, 11'h2aa, 2'd0, 0, 100, -1, 0, 1);
        chk("t3_nwr", wlog.size(), 1);
        if (wlog.size() > 0) chk("t3_din", wlog[0].d, bd[0]);

        // Early last, then a refill right behind it.
        set_beats(2, 2);
        run_txn(1, 11'h011, 2'd3, 0, 100, -1, 0, 1);
        set_beats(0, 0);
        run_txn(0, 11'h7ff, 2'd1, 0, 100, -1, 1, 0);

        // Reset after two beats, then a normal refill.
        set_beats(0, 0);
        run_txn(1, 11'h123, 2'd1, 0, 100, 2, 0, 0);
        chk("t5_busy", refill_busy, 0);
        set_beats(0, 0);
        run_txn(1, 11'h123, 2'd1, 0, 100, -1, 1, 0);
        chk("t5_nwr", wlog.size(), 4);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(3);
            k    = (kind == 1) ? $urandom_range(3) : $urandom_range(2);
            set_beats(kind, k);
            run_txn(1'($urandom), 11'($urandom), 2'($urandom), $urandom_range(80),
                    $urandom_range(100, 40), -1, kind == 0 ? 1 : 0, kind == 0 ? 0 : 1);
            if (kind == 0) chk("rnd_nwr", wlog.size(), 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
